axis_burst_reader: RTL and testbench
====================================

Name: axis_burst_reader

Overview:
- Read-side consumer for an axis FIFO.
- Watches the FIFO fill level and drains fixed-length bursts once enough words are buffered.
- Emits each burst as an AXI-stream packet with olast on the final word.
- Sits between a FIFO's output port and a packet-oriented downstream sink (DMA or serializer), so the sink only ever sees complete bursts.

Parameters:
- DATA_WIDTH, 8, width of idata/odata.
- ADDR_WIDTH, 4, width of level and of the internal word counter.
- BURST_LEN, 8, words per burst; legal range 1..2^ADDR_WIDTH-1; 0 is illegal.
- TIMEOUT, 64, idle cycles before a partial flush; used only with the optional feature; must be >= 1.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- level  in  ADDR_WIDTH  occupancy reported by the upstream FIFO (its size output).
- idata  in  DATA_WIDTH  upstream data.
- ivalid  in  1  upstream valid.
- iready  out  1  ready toward upstream (combinational).
- odata  out  DATA_WIDTH  registered downstream data.
- ovalid  out  1  registered downstream valid.
- olast  out  1  registered end-of-burst marker.
- oready  in  1  downstream ready.
- busy  out  1  high while in BURST.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, resetn).
- Reset values: state=IDLE, remain=0, odata=0, ovalid=0, olast=0, busy=0. Reset mid-burst abandons the burst immediately; any undelivered words stay in the FIFO.
- States: IDLE, BURST. remain is an ADDR_WIDTH-bit down-counter.
- IDLE:
  - iready=0.
  - If level >= BURST_LEN at a rising edge: go to BURST, remain<=BURST_LEN, busy<=1.
  - level is sampled only in IDLE.
  - The first iready can assert one cycle after the threshold is seen.
- BURST:
  - iready = !ovalid || oready.
  - Accept = ivalid && iready. On accept:
    - odata<=idata, ovalid<=1, olast<=(remain==1), remain<=remain-1.
    - If remain==1: state<=IDLE, busy<=0.
  - A drop of level during BURST is ignored. Words transfer whenever ivalid is high; the burst length is always exactly BURST_LEN.
- Output register:
  - If ovalid && oready and no accept this cycle: ovalid<=0, olast<=0.
  - While ovalid && !oready, odata, ovalid and olast hold stable (AXI-stream rule).
  - Accept and drain in the same cycle gives a seamless replacement: 1 word/cycle sustained when oready=1.
- Back-to-back bursts:
  - IDLE can re-trigger while the last word of the previous burst is still in the output register.
  - Minimum gap between bursts on the input side: 1 cycle (the IDLE cycle).
- Latency: idata to odata is 1 cycle.
- Invariant: olast is never high with ovalid low.
- Arithmetic: level >= BURST_LEN is an unsigned ADDR_WIDTH-bit compare. remain never wraps, because the state machine leaves BURST when remain reaches 1.

Optional Feature:
- Macro: AXIS_BURST_READER_TIMEOUT_EN.
- Defined:
  - A timer counts consecutive IDLE cycles with 0 < level < BURST_LEN.
  - The timer clears on entering BURST, on level==0, or on level >= BURST_LEN.
  - When the timer reaches TIMEOUT: enter BURST with remain<=level, so a short burst ends with olast as normal.
  - A full threshold takes priority if both conditions are true in the same cycle.
- Undefined: no timer logic; a partial burst waits indefinitely for level >= BURST_LEN.

Test Plan:
- Reset, BURST_LEN=4, level=3, ivalid=1 -> iready stays 0, ovalid=0, busy=0 indefinitely.
- level=4, ivalid=1, oready=1, data 0xA0..0xA3 -> iready rises 1 cycle later; odata A0..A3 on 4 consecutive cycles; olast=1 only with A3; busy falls after the A3 accept.
- Same burst with oready low for 3 cycles on the 2nd word -> odata=A1 and ovalid held stable; iready=0 during the stall; no word lost or duplicated; olast on A3.
- level held at 8, continuous traffic -> two bursts of 4; a one-cycle iready gap between them; olast on words 4 and 8; each burst has exactly 4 words.
- Assert resetn=0 after 2 of 4 words are accepted -> ovalid, olast, busy=0 immediately; after release, a new burst starts only when level >= 4.
- With AXIS_BURST_READER_TIMEOUT_EN, TIMEOUT=5, level=2 -> BURST entered after 5 idle cycles; 2 words output; olast on the 2nd. Without the macro, no output.

Source files
------------

// File: rtl/axis_burst_reader.sv
// Drains fixed-length bursts from an upstream FIFO once its level reaches BURST_LEN.
// Optional partial-burst flush after TIMEOUT idle cycles: define AXIS_BURST_READER_TIMEOUT_EN.
module axis_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] level,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  ivalid,
    output logic                  iready,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  ovalid,
    output logic                  olast,
    input  logic                  oready,
    output logic                  busy
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [ADDR_WIDTH-1:0] BL  = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
    logic [DATA_WIDTH-1:0]   odata_q, odata_d;
    logic                    ovalid_q, ovalid_d;
    logic                    olast_q, olast_d;
    logic                    full;
    logic                    timeout_hit;
    logic                    accept;
    logic                    last_acc;

    assign full     = (level >= BL);
    assign accept   = ivalid && iready;
    assign last_acc = accept && (remain_q == ONE);

`ifdef AXIS_BURST_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          partial;

    // Counts consecutive IDLE cycles holding a partial (non-empty, sub-threshold) level.
    assign partial     = (state_q == S_IDLE) && (level != '0) && !full;
    assign timeout_hit = partial && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        timer_d = '0;
        if (partial && !timeout_hit) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (full || timeout_hit) state_d = S_BURST;
            S_BURST: if (last_acc)            state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        iready = (state_q == S_BURST) && (!ovalid_q || oready);
        busy   = (state_q == S_BURST);
    end

    // Full threshold wins over the timeout length when both hold in the same cycle.
    always_comb begin
        remain_d = remain_q;
        if (state_q == S_IDLE) begin
            if (full) begin
                remain_d = BL;
            end else if (timeout_hit) begin
                remain_d = level;
            end
        end else if (accept) begin
            remain_d = remain_q - ONE;
        end
    end

    // Accept and drain in one cycle replace the word in place; a drain alone empties it.
    always_comb begin
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        if (accept) begin
            odata_d  = idata;
            ovalid_d = 1'b1;
            olast_d  = (remain_q == ONE);
        end else if (ovalid_q && oready) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            remain_q <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            remain_q <= remain_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign olast  = olast_q;

endmodule

// File: tb/tb_axis_burst_reader.sv
// Directed bench for axis_burst_reader (BURST_LEN=4, TIMEOUT=5) with an in-order scoreboard.
module tb_axis_burst_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int BL = 4;
    localparam int TO = 5;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
    localparam int IDLE_RUN = 4;
`else
    localparam int IDLE_RUN = 12;
`endif

    logic          clock = 1'b0;
    logic          resetn;
    logic [AW-1:0] level;
    logic [DW-1:0] idata;
    logic          ivalid;
    logic          iready;
    logic [DW-1:0] odata;
    logic          ovalid;
    logic          olast;
    logic          oready;
    logic          busy;

    axis_burst_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .resetn(resetn), .level(level), .idata(idata),
        .ivalid(ivalid), .iready(iready), .odata(odata), .ovalid(ovalid),
        .olast(olast), .oready(oready), .busy(busy)
    );

    always #5 clock = ~clock;

    int            vec = 0;
    int            err = 0;
    int            cnt_in = 0;
    int            exp_len = BL;
    int            out_cnt = 0;
    bit            in_hs = 1'b0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [DW:0]   sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec++;
        assert (obs === exp_v) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Handshakes are judged at the falling edge, ahead of the rising edge that completes them.
    always @(negedge clock) begin
        logic [DW:0] e;
        logic        lst;
        in_hs = resetn && ivalid && iready;
        if (resetn) begin
            chk("olast_without_ovalid", {31'd0, olast && !ovalid}, 32'd0);
            if (stall_prev) begin
                chk("stall_hold_data", {24'd0, odata}, {24'd0, hold_data});
                chk("stall_hold_last", {31'd0, olast}, {31'd0, hold_last});
                chk("stall_hold_valid", {31'd0, ovalid}, 32'd1);
            end
            if (ovalid && oready) begin
                vec++;
                assert (sb.size() > 0) else begin
                    err++;
                    $error("FAIL spurious_output observed=%0h expected=no_word", odata);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_odata", {24'd0, odata}, {24'd0, e[DW-1:0]});
                    chk("sb_olast", {31'd0, olast}, {31'd0, e[DW]});
                    out_cnt++;
                end
            end
            if (in_hs) begin
                lst = (cnt_in == exp_len - 1);
                sb.push_back({lst, idata});
                cnt_in = lst ? 0 : cnt_in + 1;
            end
        end
        stall_prev = resetn && ovalid && !oready;
        hold_data  = odata;
        hold_last  = olast;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (in_hs) idata = idata + 8'd1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        sb.delete();
        cnt_in = 0;
        stall_prev = 1'b0;
    endtask

    initial begin
        int base;
        resetn = 1'b1;
        level  = '0;
        idata  = '0;
        ivalid = 1'b0;
        oready = 1'b1;
        #2;
        apply_reset();
        #10;
        chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
        chk("rst_olast", {31'd0, olast}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_iready", {31'd0, iready}, 32'd0);
        chk("rst_odata", {24'd0, odata}, 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Below threshold: nothing moves.
        level  = 4'd3;
        ivalid = 1'b1;
        idata  = 8'hA0;
        for (int i = 0; i < IDLE_RUN; i++) begin
            tick();
            chk("below_iready", {31'd0, iready}, 32'd0);
            chk("below_ovalid", {31'd0, ovalid}, 32'd0);
            chk("below_busy", {31'd0, busy}, 32'd0);
        end

        // Single burst A0..A3 at full rate; level drop during BURST is ignored.
        level = 4'd4;
        tick();
        level = 4'd0;
        chk("b1_busy", {31'd0, busy}, 32'd1);
        chk("b1_iready", {31'd0, iready}, 32'd1);
        chk("b1_ovalid0", {31'd0, ovalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b1_odata", {24'd0, odata}, 32'hA0 + i);
            chk("b1_ovalid", {31'd0, ovalid}, 32'd1);
            chk("b1_olast", {31'd0, olast}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("b1_busy_end", {31'd0, busy}, 32'd0);
        tick();
        chk("b1_drained_ovalid", {31'd0, ovalid}, 32'd0);
        chk("b1_drained_olast", {31'd0, olast}, 32'd0);
        chk("b1_sb_empty", sb.size(), 32'd0);

        // Same burst with a 3-cycle stall on the second word.
        idata = 8'hA0;
        level = 4'd4;
        tick();
        level = 4'd0;
        tick();
        tick();
        chk("st_odata_a1", {24'd0, odata}, 32'hA1);
        oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_iready", {31'd0, iready}, 32'd0);
            chk("st_ovalid", {31'd0, ovalid}, 32'd1);
            chk("st_odata", {24'd0, odata}, 32'hA1);
        end
        oready = 1'b1;
        tick();
        chk("st_odata_a2", {24'd0, odata}, 32'hA2);
        tick();
        chk("st_odata_a3", {24'd0, odata}, 32'hA3);
        chk("st_olast_a3", {31'd0, olast}, 32'd1);
        tick();
        chk("st_drained", {31'd0, ovalid}, 32'd0);
        chk("st_sb_empty", sb.size(), 32'd0);

        // Level held at 8: two bursts with a one-cycle iready gap.
        base  = out_cnt;
        idata = 8'hC0;
        level = 4'd8;
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("b2b_iready", {31'd0, iready}, (i == 4) ? 32'd0 : 32'd1);
            if (i == 4) begin
                chk("b2b_last_held", {31'd0, olast}, 32'd1);
                chk("b2b_last_data", {24'd0, odata}, 32'hC3);
            end
            tick();
        end
        level = 4'd0;
        tick();
        tick();
        chk("b2b_words", out_cnt - base, 32'd8);
        chk("b2b_sb_empty", sb.size(), 32'd0);

        // Reset after two accepted words abandons the burst.
        idata = 8'hD0;
        level = 4'd4;
        tick();
        level = 4'd0;
        tick();
        tick();
        apply_reset();
        #1;
        chk("mid_rst_ovalid", {31'd0, ovalid}, 32'd0);
        chk("mid_rst_olast", {31'd0, olast}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_iready", {31'd0, iready}, 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        level  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", {31'd0, busy}, 32'd0);
        end
        base  = out_cnt;
        idata = 8'hD2;
        level = 4'd4;
        tick();
        level = 4'd0;
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_words", out_cnt - base, 32'd4);
        chk("post_rst_sb_empty", sb.size(), 32'd0);

        // Partial level of 2.
        base    = out_cnt;
        idata   = 8'hE0;
        exp_len = 2;
        level   = 4'd2;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("to_wait_busy", {31'd0, busy}, 32'd0);
        end
        tick();
        level = 4'd0;
        chk("to_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("to_odata_e0", {24'd0, odata}, 32'hE0);
        chk("to_olast_e0", {31'd0, olast}, 32'd0);
        tick();
        chk("to_odata_e1", {24'd0, odata}, 32'hE1);
        chk("to_olast_e1", {31'd0, olast}, 32'd1);
        chk("to_busy_end", {31'd0, busy}, 32'd0);
        tick();
        chk("to_words", out_cnt - base, 32'd2);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nto_busy", {31'd0, busy}, 32'd0);
            chk("nto_ovalid", {31'd0, ovalid}, 32'd0);
        end
        level = 4'd0;
        chk("nto_words", out_cnt - base, 32'd0);
`endif
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
